// File: rtl/fft_frame_loader_if.sv
// rtl/fft_frame_loader_if.sv - sample stream and frame handshake bundle for fft_frame_loader
interface fft_frame_loader_if #(
    parameter int DATA_W = 32,
    parameter int N      = 32,
    parameter int LOG2N  = 5
);
    logic                  s_valid;
    logic [DATA_W-1:0]     s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  frame_valid;
    logic [N*DATA_W-1:0]   frame_data;
    logic                  frame_ack;
    logic                  frame_err;
    logic [LOG2N-1:0]      wr_idx;

    modport slave (
        input  s_valid, s_data, s_last, frame_ack,
        output s_ready, frame_valid, frame_data, frame_err, wr_idx
    );

    modport master (
        output s_valid, s_data, s_last, frame_ack,
        input  s_ready, frame_valid, frame_data, frame_err, wr_idx
    );
endinterface

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong frame assembler feeding the parallel FFT input bus
module fft_frame_loader #(
    parameter int DATA_W = 32,
    parameter int N      = 32,
    parameter int LOG2N  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    fft_frame_loader_if.slave bus
);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [DATA_W-1:0]   r_bank [2][N];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [LOG2N-1:0]    r_wr_cnt;
    logic                r_err;

    logic                w_accept;
    logic                w_take;
    logic                w_at_last;
    logic                w_early;
    logic [N*DATA_W-1:0] w_frame;

    // s_ready depends only on state so a sender may wait on it before raising s_valid
    assign bus.s_ready     = ~r_full[r_wr_bank];
    assign bus.frame_valid = r_full[r_rd_bank];
    assign bus.frame_err   = r_err;
    assign bus.wr_idx      = r_wr_cnt;
    assign bus.frame_data  = w_frame;

    assign w_accept  = bus.s_valid & ~r_full[r_wr_bank];
    assign w_take    = r_full[r_rd_bank] & bus.frame_ack;
    assign w_at_last = (r_wr_cnt == LAST_IDX);
    assign w_early   = bus.s_last & ~w_at_last;

    always_comb begin
        w_frame = '0;
        for (int i = 0; i < N; i++) begin
            w_frame[i*DATA_W +: DATA_W] = r_bank[r_rd_bank][i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_err     <= 1'b0;
        end else begin
            // Either an early or a missing s_last flags a misaligned frame
            r_err <= w_accept & (bus.s_last ^ w_at_last);

            if (w_take) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end

            // The write bank is never full, so it can never collide with the bank being taken
            if (w_accept) begin
                if (w_early) begin
                    r_wr_cnt <= '0;
                end else begin
                    r_bank[r_wr_bank][r_wr_cnt] <= bus.s_data;
                    if (w_at_last) begin
                        r_full[r_wr_bank] <= 1'b1;
                        r_wr_bank         <= ~r_wr_bank;
                        r_wr_cnt          <= '0;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_loader.sv
// tb/tb_fft_frame_loader.sv - directed self-checking bench for fft_frame_loader
module tb_fft_frame_loader;
    localparam int DATA_W = 32;
    localparam int N      = 32;
    localparam int LOG2N  = 5;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   err_cnt;

    fft_frame_loader_if #(.DATA_W(DATA_W), .N(N), .LOG2N(LOG2N)) bus ();

    fft_frame_loader #(.DATA_W(DATA_W), .N(N), .LOG2N(LOG2N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.frame_err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] slice(input int i);
        return bus.frame_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds the sample until it is accepted; leaves s_valid high for back-to-back streaming
    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        bit ok;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bus.s_ready;
            step();
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] base, input bit with_last, input bit ack_on_last);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1 && ack_on_last) bus.frame_ack = 1'b1;
            send(base + DATA_W'(i), (i == N - 1) ? with_last : 1'b0);
            bus.frame_ack = 1'b0;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.frame_ack = 1'b0;
        #12;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_frame_valid", bus.frame_valid, 0);
        chk("rst_frame_data", |bus.frame_data, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_wr_idx", bus.wr_idx, 0);
        step();
        rst_n = 1'b1;
        step();

        // Single frame 1..32
        for (int i = 0; i < N - 1; i++) send(DATA_W'(i + 1), 1'b0);
        chk("single_wr_idx_31", bus.wr_idx, 31);
        chk("single_fv_before", bus.frame_valid, 0);
        send(32'h20, 1'b1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("single_fv_after", bus.frame_valid, 1);
        chk("single_slice0", slice(0), 32'h1);
        chk("single_slice31", slice(31), 32'h20);
        chk("single_err", bus.frame_err, 0);
        chk("single_wr_idx_wrap", bus.wr_idx, 0);
        ack_pulse();
        chk("single_fv_taken", bus.frame_valid, 0);

        // Ping-pong: A then B with no ack, C stalls
        for (int i = 0; i < 2 * N; i++) send(DATA_W'(i + 1), (i % N) == N - 1);
        bus.s_data  = 32'h41;
        bus.s_last  = 1'b0;
        chk("pp_s_ready_low", bus.s_ready, 0);
        chk("pp_slice0_A", slice(0), 32'h1);
        step(); step(); step();
        chk("pp_stall_wr_idx", bus.wr_idx, 0);
        chk("pp_hold_slice0_A", slice(0), 32'h1);
        chk("pp_hold_slice31_A", slice(31), 32'h20);
        chk("pp_hold_fv", bus.frame_valid, 1);
        ack_pulse();
        chk("pp_fv_B", bus.frame_valid, 1);
        chk("pp_slice0_B", slice(0), 32'h21);
        chk("pp_slice31_B", slice(31), 32'h40);
        chk("pp_s_ready_high", bus.s_ready, 1);
        send_frame(32'h41, 1'b1, 1'b0);
        chk("pp_both_full", bus.s_ready, 0);

        // Take B, then complete D on the same edge that C is taken
        ack_pulse();
        chk("sim_slice0_C", slice(0), 32'h41);
        chk("sim_s_ready", bus.s_ready, 1);
        send_frame(32'h61, 1'b1, 1'b1);
        chk("sim_fv_D", bus.frame_valid, 1);
        chk("sim_slice0_D", slice(0), 32'h61);
        chk("sim_slice31_D", slice(31), 32'h80);
        chk("sim_s_ready_after", bus.s_ready, 1);
        chk("sim_no_err", err_cnt, 0);
        ack_pulse();
        chk("sim_fv_drained", bus.frame_valid, 0);

        // Early s_last on the 5th sample
        for (int i = 1; i <= 4; i++) send(32'hDEAD0000 + DATA_W'(i), 1'b0);
        send(32'hDEAD0005, 1'b1);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk("early_err_pulse", bus.frame_err, 1);
        chk("early_wr_idx", bus.wr_idx, 0);
        chk("early_no_fv", bus.frame_valid, 0);
        step();
        chk("early_err_clear", bus.frame_err, 0);
        send_frame(32'hBEEF0000, 1'b1, 1'b0);
        chk("early_clean_fv", bus.frame_valid, 1);
        chk("early_clean_slice0", slice(0), 32'hBEEF0000);
        chk("early_clean_slice31", slice(31), 32'hBEEF001F);
        chk("early_err_count", err_cnt, 1);
        ack_pulse();

        // Missing s_last
        send_frame(32'hA0000000, 1'b0, 1'b0);
        chk("miss_fv", bus.frame_valid, 1);
        chk("miss_err_pulse", bus.frame_err, 1);
        chk("miss_slice5", slice(5), 32'hA0000005);
        step();
        chk("miss_err_clear", bus.frame_err, 0);
        chk("miss_err_count", err_cnt, 2);

        // Reset with one frame pending and a partial one in progress
        for (int i = 0; i < 10; i++) send(32'hC0000000 + DATA_W'(i), 1'b0);
        bus.s_valid = 1'b0;
        chk("mid_wr_idx_10", bus.wr_idx, 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fv", bus.frame_valid, 0);
        chk("mid_rst_data", |bus.frame_data, 0);
        chk("mid_rst_s_ready", bus.s_ready, 1);
        chk("mid_rst_wr_idx", bus.wr_idx, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_fv", bus.frame_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
